// File: rtl/stack_alu_sequencer_pkg.sv
// Shared definitions for the stack ALU sequencer.
//   - op_t        : opcode encodings shared with the control unit
//   - ST_*        : sequencer state constants
//   - ERR_*       : bit positions of the error-flag vector
// Optional feature macro: STACK_SEQ_DIV_EN (adds the DIV_WAIT state).
package stack_alu_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_t;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_POP1     = 3'd1;
    localparam state_t ST_POP2     = 3'd2;
    localparam state_t ST_EXEC     = 3'd3;
    localparam state_t ST_PUSH     = 3'd4;
`ifdef STACK_SEQ_DIV_EN
    localparam state_t ST_DIV_WAIT = 3'd5;
`endif

    localparam int ERR_UNDERFLOW = 0;
    localparam int ERR_DIV0      = 1;
    localparam int ERR_ILLEGAL   = 2;
    localparam int ERR_W         = 3;

endpackage

// File: rtl/stack_div_iter.sv
// Iterative restoring signed divider, one quotient bit per clock.
// The first bit is resolved on the start edge, so `done` rises DATA_W
// cycles after the cycle in which `start` was high.
// Ports:
//   clk, reset          : clock, synchronous active-high reset (control only)
//   start               : one-cycle pulse, samples dividend/divisor
//   dividend, divisor   : signed operands (divisor must be non-zero)
//   done                : one-cycle pulse, quotient valid while high
//   quotient            : signed quotient, truncated toward zero
module stack_div_iter #(
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] dividend,
    input  logic signed [DATA_W-1:0] divisor,
    output logic                     done,
    output logic signed [DATA_W-1:0] quotient
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] dvs;
    logic              neg;
    logic [CNT_W-1:0]  cnt;

    // Magnitude fits in DATA_W unsigned bits, including the most-negative value.
    function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v);
        return v[DATA_W-1] ? DATA_W'(-v) : DATA_W'(v);
    endfunction

    // One restoring step: shift the next dividend bit into the remainder,
    // subtract the divisor when it fits, shift the outcome into the quotient.
    function automatic logic [2*DATA_W-1:0] step(input logic [DATA_W-1:0] r,
                                                 input logic [DATA_W-1:0] q,
                                                 input logic [DATA_W-1:0] d);
        logic [DATA_W:0] t;
        logic            ge;
        t  = {r, q[DATA_W-1]};
        ge = (t >= {1'b0, d});
        return {DATA_W'(t - (ge ? {1'b0, d} : {(DATA_W+1){1'b0}})), q[DATA_W-2:0], ge};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                cnt  <= CNT_W'(DATA_W - 1);
                done <= (DATA_W == 1);
            end else if (cnt != '0) begin
                cnt  <= cnt - CNT_W'(1);
                done <= (cnt == CNT_W'(1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            {rem, quo} <= step('0, magnitude(dividend), magnitude(divisor));
            dvs        <= magnitude(divisor);
            neg        <= dividend[DATA_W-1] ^ divisor[DATA_W-1];
        end else if (cnt != '0) begin
            {rem, quo} <= step(rem, quo, dvs);
        end
    end

    // Most-negative / -1 wraps back to most-negative here; the caller flags it.
    assign quotient = neg ? -signed'(quo) : signed'(quo);

endmodule

// File: rtl/stack_alu_sequencer.sv
// Sequences one ADD/SUB/MUL/DIV instruction against the operand stack:
// pop in1 (old TOS), pop in2, compute in1 op in2, push the result.
// Optional feature macro: STACK_SEQ_DIV_EN -- when defined DIV runs through
// stack_div_iter; when undefined op_code 3 ends at once with err_illegal.
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   op_valid, op_code, op_ready    : opcode handshake with the control unit
//   stack_tos, stack_count         : current stack top value and occupancy
//   stack_pop, stack_push          : one-cycle stack strobes
//   stack_push_data                : value pushed, valid with stack_push
//   busy, done                     : activity level, completion pulse
//   result, carry_out              : registered result and carry/overflow
//   err_underflow/div0/illegal     : registered error flags, valid with done
module stack_alu_sequencer
    import stack_alu_sequencer_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEPTH_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               op_valid,
    input  logic [1:0]         op_code,
    output logic               op_ready,
    input  logic [DATA_W-1:0]  stack_tos,
    input  logic [DEPTH_W-1:0] stack_count,
    output logic               stack_pop,
    output logic               stack_push,
    output logic [DATA_W-1:0]  stack_push_data,
    output logic               busy,
    output logic               done,
    output logic [DATA_W-1:0]  result,
    output logic               carry_out,
    output logic               err_underflow,
    output logic               err_div0,
    output logic               err_illegal
);

    state_t                   state;
    state_t                   next_state;
    op_t                      op_q;
    logic signed [DATA_W-1:0] in1;
    logic signed [DATA_W-1:0] in2;
    logic [ERR_W-1:0]         err;
    logic                     accept;
    logic                     illegal_op;
    logic                     short_stack;
    logic                     early_exit;

    function automatic logic [DATA_W:0] add_carry(input logic signed [DATA_W-1:0] a,
                                                  input logic signed [DATA_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // The extra top bit of the widened difference is the unsigned borrow.
    function automatic logic [DATA_W:0] sub_borrow(input logic signed [DATA_W-1:0] a,
                                                   input logic signed [DATA_W-1:0] b);
        return {1'b0, a} - {1'b0, b};
    endfunction

    // Overflow when the full product differs from its truncated value re-extended.
    function automatic logic [DATA_W:0] mul_ovf(input logic signed [DATA_W-1:0] a,
                                                input logic signed [DATA_W-1:0] b);
        logic signed [2*DATA_W-1:0] p;
        logic signed [DATA_W-1:0]   lo;
        p  = (2*DATA_W)'(a) * (2*DATA_W)'(b);
        lo = p[DATA_W-1:0];
        return {(p != (2*DATA_W)'(lo)), lo};
    endfunction

    assign op_ready        = (state == ST_IDLE);
    assign busy            = !op_ready;
    assign accept          = op_valid && op_ready;
    assign short_stack     = (stack_count < DEPTH_W'(2));
    assign early_exit      = illegal_op || short_stack;
    assign stack_push_data = result;
    assign err_underflow   = err[ERR_UNDERFLOW];
    assign err_div0        = err[ERR_DIV0];
    assign err_illegal     = err[ERR_ILLEGAL];

`ifdef STACK_SEQ_DIV_EN
    localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    logic                     div_start;
    logic                     div_done;
    logic signed [DATA_W-1:0] div_quot;

    assign illegal_op = 1'b0;
    assign div_start  = (state == ST_EXEC) && (op_q == OP_DIV) && (in2 != '0);

    stack_div_iter #(.DATA_W(DATA_W)) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (in1),
        .divisor  (in2),
        .done     (div_done),
        .quotient (div_quot)
    );
`else
    assign illegal_op = (op_code == OP_DIV);
`endif

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (accept && !early_exit) next_state = ST_POP1;
            ST_POP1: next_state = ST_POP2;
            ST_POP2: next_state = ST_EXEC;
`ifdef STACK_SEQ_DIV_EN
            ST_EXEC: next_state = (op_q == OP_DIV && in2 != '0) ? ST_DIV_WAIT : ST_PUSH;
            ST_DIV_WAIT: if (div_done) next_state = ST_PUSH;
`else
            ST_EXEC: next_state = ST_PUSH;
`endif
            ST_PUSH: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Strobes are registered from next_state so they line up with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            stack_pop  <= 1'b0;
            stack_push <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            carry_out  <= 1'b0;
            err        <= '0;
        end else begin
            state      <= next_state;
            stack_pop  <= (next_state == ST_POP1) || (next_state == ST_POP2);
            stack_push <= (next_state == ST_PUSH);
            done       <= (next_state == ST_PUSH) || (accept && early_exit);

            if (accept) begin
                err                <= '0;
                err[ERR_ILLEGAL]   <= illegal_op;
                err[ERR_UNDERFLOW] <= short_stack && !illegal_op;
            end

            if (state == ST_EXEC) begin
                case (op_q)
                    OP_ADD:  {carry_out, result} <= add_carry(in1, in2);
                    OP_SUB:  {carry_out, result} <= sub_borrow(in1, in2);
                    OP_MUL:  {carry_out, result} <= mul_ovf(in1, in2);
                    default: begin
`ifdef STACK_SEQ_DIV_EN
                        if (in2 == '0) begin
                            result        <= '0;
                            carry_out     <= 1'b0;
                            err[ERR_DIV0] <= 1'b1;
                        end else begin
                            carry_out <= (in1 == MOST_NEG) && (in2 == '1);
                        end
`endif
                    end
                endcase
            end

`ifdef STACK_SEQ_DIV_EN
            if (state == ST_DIV_WAIT && div_done) result <= div_quot;
`endif
        end
    end

    // Operand latches: in1 is the old TOS, in2 the entry beneath it.
    always_ff @(posedge clk) begin
        if (accept) op_q <= op_t'(op_code);
        if (state == ST_POP1) in1 <= stack_tos;
        if (state == ST_POP2) in2 <= stack_tos;
    end

endmodule
